// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync generator with a lookahead pixel-request port and gated RGB.
// Define VGA_TESTPAT_EN to build the internal 8-bar colour pattern selected by pattern_en.

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned R_BITS   = 3,
    parameter int unsigned G_BITS   = 3,
    parameter int unsigned B_BITS   = 2,
    parameter int unsigned PIPE_LAT = 1,
    localparam int unsigned XW      = $clog2(H_ACTIVE),
    localparam int unsigned YW      = $clog2(V_ACTIVE)
) (
    input  logic              clk_25M,
    input  logic              rst,
    input  logic [R_BITS-1:0] red_in,
    input  logic [G_BITS-1:0] green_in,
    input  logic [B_BITS-1:0] blue_in,
    input  logic              pattern_en,
    output logic              req_valid,
    output logic [XW-1:0]     x_req,
    output logic [YW-1:0]     y_req,
    output logic              frame_start,
    output logic [R_BITS-1:0] vgaRed,
    output logic [G_BITS-1:0] vgaGreen,
    output logic [B_BITS-1:0] vgaBlue,
    output logic              Hsync,
    output logic              Vsync
);

    localparam int unsigned H_T         = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_T         = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW          = $clog2(H_T);
    localparam int unsigned VW          = $clog2(V_T);
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

`ifdef VGA_TESTPAT_EN
    localparam int unsigned X_TAPS = PIPE_LAT;
    localparam int unsigned BAR_W  = H_ACTIVE / 8;

    if (BAR_W == 0) begin : g_bar_err
        $error("vga_timing_gen: H_ACTIVE must be at least 8 for the test pattern");
    end
`else
    localparam int unsigned X_TAPS = 0;
`endif

    if (PIPE_LAT > 7 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_err
        $error("vga_timing_gen: PIPE_LAT must be 0..7 and all timing parameters non-zero");
    end

    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [31:0]       h_pos, v_pos;
    logic              h_act, v_act;

    // Index 0 of each delay line is the stage-0 register; index PIPE_LAT feeds the output stage.
    logic [PIPE_LAT:0] hs_dl_q, hs_dl_d;
    logic [PIPE_LAT:0] vs_dl_q, vs_dl_d;
    logic [PIPE_LAT:0] de_dl_q, de_dl_d;
    logic [XW-1:0]     x_dl_q [X_TAPS+1];
    logic [XW-1:0]     x_dl_d [X_TAPS+1];
    logic [YW-1:0]     y_req_q, y_req_d;
    logic              frame_start_q, frame_start_d;

    logic [R_BITS-1:0] red_src, vga_red_q, vga_red_d;
    logic [G_BITS-1:0] green_src, vga_green_q, vga_green_d;
    logic [B_BITS-1:0] blue_src, vga_blue_q, vga_blue_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;

    always_comb begin
        h_pos   = 32'(h_cnt_q);
        v_pos   = 32'(v_cnt_q);
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_pos == H_T - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (v_pos == V_T - 1) ? '0 : v_cnt_q + VW'(1);
        end

        h_act         = (h_pos >= H_ACT_START) && (h_pos < H_ACT_END);
        v_act         = (v_pos >= V_ACT_START) && (v_pos < V_ACT_END);
        hs_dl_d[0]    = (h_pos < H_SYNC);
        vs_dl_d[0]    = (v_pos < V_SYNC);
        de_dl_d[0]    = h_act && v_act;
        x_dl_d[0]     = (h_act && v_act) ? XW'(h_pos - H_ACT_START) : '0;
        y_req_d       = (h_act && v_act) ? YW'(v_pos - V_ACT_START) : '0;
        frame_start_d = (h_pos == H_ACT_START) && (v_pos == V_ACT_START);

        for (int unsigned i = 1; i <= PIPE_LAT; i++) begin
            hs_dl_d[i] = hs_dl_q[i-1];
            vs_dl_d[i] = vs_dl_q[i-1];
            de_dl_d[i] = de_dl_q[i-1];
        end
        for (int unsigned i = 1; i <= X_TAPS; i++) begin
            x_dl_d[i] = x_dl_q[i-1];
        end
    end

`ifdef VGA_TESTPAT_EN
    logic [2:0] bar_idx;

    always_comb begin
        bar_idx   = 3'(32'(x_dl_q[X_TAPS]) / BAR_W);
        red_src   = red_in;
        green_src = green_in;
        blue_src  = blue_in;
        if (pattern_en) begin
            red_src   = bar_idx[2] ? '1 : '0;
            green_src = bar_idx[1] ? '1 : '0;
            blue_src  = bar_idx[0] ? '1 : '0;
        end
    end
`else
    logic unused_pattern_en;
    assign unused_pattern_en = pattern_en;

    always_comb begin
        red_src   = red_in;
        green_src = green_in;
        blue_src  = blue_in;
    end
`endif

    always_comb begin
        hsync_d     = hs_dl_q[PIPE_LAT] ? H_POL : ~H_POL;
        vsync_d     = vs_dl_q[PIPE_LAT] ? V_POL : ~V_POL;
        vga_red_d   = de_dl_q[PIPE_LAT] ? red_src   : '0;
        vga_green_d = de_dl_q[PIPE_LAT] ? green_src : '0;
        vga_blue_d  = de_dl_q[PIPE_LAT] ? blue_src  : '0;
    end

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_dl_q       <= '0;
            vs_dl_q       <= '0;
            de_dl_q       <= '0;
            for (int unsigned i = 0; i <= X_TAPS; i++) begin
                x_dl_q[i] <= '0;
            end
            y_req_q       <= '0;
            frame_start_q <= 1'b0;
            vga_red_q     <= '0;
            vga_green_q   <= '0;
            vga_blue_q    <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_dl_q       <= hs_dl_d;
            vs_dl_q       <= vs_dl_d;
            de_dl_q       <= de_dl_d;
            for (int unsigned i = 0; i <= X_TAPS; i++) begin
                x_dl_q[i] <= x_dl_d[i];
            end
            y_req_q       <= y_req_d;
            frame_start_q <= frame_start_d;
            vga_red_q     <= vga_red_d;
            vga_green_q   <= vga_green_d;
            vga_blue_q    <= vga_blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign req_valid   = de_dl_q[0];
    assign x_req       = x_dl_q[0];
    assign y_req       = y_req_q;
    assign frame_start = frame_start_q;
    assign vgaRed      = vga_red_q;
    assign vgaGreen    = vga_green_q;
    assign vgaBlue     = vga_blue_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small randomised instance vs arithmetic frame model, default-timing
// vector table, and a VESA 800x600 instance for sync pulse widths.

module tb_vga_timing_gen;

    // Small instance: H 16/2/3/4 (25 clocks), V 8/1/2/2 (13 lines), PIPE_LAT=3, Hsync active-high.
    localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HB = 4;
    localparam int A_VA = 8,  A_VFP = 1, A_VS = 2, A_VB = 2;
    localparam int A_HT = A_HS + A_HB + A_HA + A_HFP;
    localparam int A_VT = A_VS + A_VB + A_VA + A_VFP;
    localparam int A_FT = A_HT * A_VT;
    localparam int A_LAT = 3;
    localparam bit A_HPOL = 1'b1, A_VPOL = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_bc = 1'b1;

    logic [2:0] a_red_in = '0, a_green_in = '0;
    logic [1:0] a_blue_in = '0;
    logic       a_pat = 1'b0;
    logic       a_req, a_fs, a_hs, a_vs;
    logic [3:0] a_x;
    logic [2:0] a_y, a_r, a_g;
    logic [1:0] a_b;

    logic       b_req, b_fs, b_hs, b_vs;
    logic [9:0] b_x;
    logic [8:0] b_y;
    logic [2:0] b_r, b_g;
    logic [1:0] b_b;

    logic       c_req, c_fs, c_hs, c_vs;
    logic [9:0] c_x, c_y;
    logic [2:0] c_r, c_g;
    logic [1:0] c_b;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VB),
        .H_POL(A_HPOL), .V_POL(A_VPOL), .PIPE_LAT(A_LAT)
    ) dut_a (
        .clk_25M(clk), .rst(rst_a), .red_in(a_red_in), .green_in(a_green_in),
        .blue_in(a_blue_in), .pattern_en(a_pat), .req_valid(a_req), .x_req(a_x),
        .y_req(a_y), .frame_start(a_fs), .vgaRed(a_r), .vgaGreen(a_g), .vgaBlue(a_b),
        .Hsync(a_hs), .Vsync(a_vs)
    );

    vga_timing_gen dut_b (
        .clk_25M(clk), .rst(rst_bc), .red_in(3'd5), .green_in(3'd2), .blue_in(2'd1),
        .pattern_en(1'b0), .req_valid(b_req), .x_req(b_x), .y_req(b_y),
        .frame_start(b_fs), .vgaRed(b_r), .vgaGreen(b_g), .vgaBlue(b_b),
        .Hsync(b_hs), .Vsync(b_vs)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_c (
        .clk_25M(clk), .rst(rst_bc), .red_in(3'd0), .green_in(3'd0), .blue_in(2'd0),
        .pattern_en(1'b0), .req_valid(c_req), .x_req(c_x), .y_req(c_y),
        .frame_start(c_fs), .vgaRed(c_r), .vgaGreen(c_g), .vgaBlue(c_b),
        .Hsync(c_hs), .Vsync(c_vs)
    );

    int vectors = 0, miscompares = 0;
    int ka = 0, kb = 0;
    logic [2:0] rs = '0;
    logic [1:0] bs = '0;
    logic       ps = 1'b0;
    logic [2:0] hist [0:A_LAT];
    int a_req_cnt = 0, a_frames = 0;

    typedef struct { bit hs; bit vs; bit de; int x; int y; } mpos_t;

    // Position p counts pixel clocks from the first raster position (0,0); p<0 means still in reset.
    function automatic mpos_t a_model(int p);
        mpos_t r;
        int f, h, v;
        r = '{hs: 1'b0, vs: 1'b0, de: 1'b0, x: 0, y: 0};
        if (p < 0) return r;
        f = p % A_FT;
        h = f % A_HT;
        v = f / A_HT;
        r.hs = (h < A_HS);
        r.vs = (v < A_VS);
        if (h >= A_HS + A_HB && h < A_HS + A_HB + A_HA && v >= A_VS + A_VB && v < A_VS + A_VB + A_VA) begin
            r.de = 1'b1;
            r.x  = h - (A_HS + A_HB);
            r.y  = v - (A_VS + A_VB);
        end
        return r;
    endfunction

    task automatic check_a();
        mpos_t q, p;
        logic [18:0] got, exp;
        logic [2:0] er, eg;
        logic [1:0] eb;
        int bar;
        q = a_model(ka - 1);
        p = a_model(ka - 2 - A_LAT);
        er = '0; eg = '0; eb = '0;
        if (p.de) begin
            er = rs;
            eg = 3'(p.x % 8);
            eb = bs;
`ifdef VGA_TESTPAT_EN
            if (ps) begin
                bar = p.x / (A_HA / 8);
                er = bar[2] ? 3'b111 : 3'b000;
                eg = bar[1] ? 3'b111 : 3'b000;
                eb = bar[0] ? 2'b11 : 2'b00;
            end
`else
            bar = 0;
`endif
        end
        exp = {q.de, q.de && q.x == 0 && q.y == 0, 4'(q.x), 3'(q.y),
               p.hs ? A_HPOL : ~A_HPOL, p.vs ? A_VPOL : ~A_VPOL, er, eg, eb};
        got = {a_req, a_fs, a_x, a_y, a_hs, a_vs, a_r, a_g, a_b};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL a_cycle k=%0d got{req,fs,x,y,hs,vs,r,g,b}=%h required=%h", ka, got, exp);
        end
    endtask

    task automatic drive_a();
        for (int i = A_LAT; i > 0; i--) hist[i] = hist[i-1];
        hist[0]    = a_x[2:0];
        a_green_in = hist[A_LAT];
        a_red_in   = 3'($urandom);
        a_blue_in  = 2'($urandom);
        a_pat      = 1'($urandom);
    endtask

    task automatic tick();
        logic ra, rb;
        ra = rst_a;
        rb = rst_bc;
        rs = a_red_in;
        bs = a_blue_in;
        ps = a_pat;
        @(posedge clk);
        #1;
        ka = ra ? 0 : ka + 1;
        kb = rb ? 0 : kb + 1;
        check_a();
        if (ka == 0) begin
            a_frames  = 0;
            a_req_cnt = 0;
        end else if (a_fs) begin
            if (a_frames > 0) begin
                vectors++;
                if (a_req_cnt != A_HA * A_VA) begin
                    miscompares++;
                    $display("FAIL a_req_per_frame got=%0d required=%0d", a_req_cnt, A_HA * A_VA);
                end
            end
            a_frames++;
            a_req_cnt = 0;
        end
        if (a_req) a_req_cnt++;
        drive_a();
    endtask

    typedef struct { int k; bit hs; bit vs; bit req; int x; int y; bit fs; bit de; } vec_t;
    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic check_b(int i);
        logic [30:0] got, exp;
        exp = {tbl[i].req, tbl[i].fs, 10'(tbl[i].x), 9'(tbl[i].y), tbl[i].hs, tbl[i].vs,
               tbl[i].de ? 3'd5 : 3'd0, tbl[i].de ? 3'd2 : 3'd0, tbl[i].de ? 2'd1 : 2'd0};
        got = {b_req, b_fs, b_x, b_y, b_hs, b_vs, b_r, b_g, b_b};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL b_vec[%0d] k=%0d got{req,fs,x,y,hs,vs,r,g,b}=%h required=%h", i, kb, got, exp);
        end
    endtask

    task automatic expect_int(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    initial begin
        int ti, c_hs_hi, c_vs_hi, n;
        bit found;
        logic [18:0] got;

        // Default 640x480, PIPE_LAT=1: requests lead position k-1, pins show position k-3.
        tbl[0]  = '{k: 0,     hs: 1, vs: 1, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[1]  = '{k: 1,     hs: 1, vs: 1, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[2]  = '{k: 3,     hs: 0, vs: 0, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[3]  = '{k: 98,    hs: 0, vs: 0, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[4]  = '{k: 99,    hs: 1, vs: 0, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[5]  = '{k: 802,   hs: 1, vs: 0, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[6]  = '{k: 803,   hs: 0, vs: 0, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[7]  = '{k: 1603,  hs: 0, vs: 1, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[8]  = '{k: 28145, hs: 1, vs: 1, req: 1, x: 0,   y: 0, fs: 1, de: 0};
        tbl[9]  = '{k: 28146, hs: 1, vs: 1, req: 1, x: 1,   y: 0, fs: 0, de: 0};
        tbl[10] = '{k: 28147, hs: 1, vs: 1, req: 1, x: 2,   y: 0, fs: 0, de: 1};
        tbl[11] = '{k: 28784, hs: 1, vs: 1, req: 1, x: 639, y: 0, fs: 0, de: 1};
        tbl[12] = '{k: 28785, hs: 1, vs: 1, req: 0, x: 0,   y: 0, fs: 0, de: 1};
        tbl[13] = '{k: 28787, hs: 1, vs: 1, req: 0, x: 0,   y: 0, fs: 0, de: 0};
        tbl[14] = '{k: 28945, hs: 1, vs: 1, req: 1, x: 0,   y: 1, fs: 0, de: 0};

        for (int i = 0; i <= A_LAT; i++) hist[i] = '0;

        for (int i = 0; i < 5; i++) tick();
        check_b(0);
        ti = 1;
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        c_hs_hi = 0;
        c_vs_hi = 0;
        for (int i = 0; i < 29000; i++) begin
            tick();
            if (ti < NV && kb == tbl[ti].k) begin
                check_b(ti);
                ti++;
            end
            if (kb >= 3 && kb < 3 + 1056 && c_hs === 1'b1) c_hs_hi++;
            if (kb >= 3 && kb < 3 + 5 * 1056 && c_vs === 1'b1) c_vs_hi++;
        end
        expect_int("b_table_reached", ti, NV);
        expect_int("c_hsync_high_per_line", c_hs_hi, 128);
        expect_int("c_vsync_high_clocks", c_vs_hi, 4 * 1056);

        // Asynchronous reset in the middle of an active line.
        found = 1'b0;
        for (int i = 0; i < 2 * A_FT && !found; i++) begin
            tick();
            if (a_req === 1'b1 && a_x == 4'd5 && a_y == 3'd3) found = 1'b1;
        end
        expect_int("a_midline_found", int'(found), 1);
        #2;
        rst_a = 1'b1;
        #1;
        got = {a_req, a_fs, a_x, a_y, a_hs, a_vs, a_r, a_g, a_b};
        vectors++;
        if (got !== {1'b0, 1'b0, 4'd0, 3'd0, ~A_HPOL, ~A_VPOL, 3'd0, 3'd0, 2'd0}) begin
            miscompares++;
            $display("FAIL a_async_reset got=%h required=%h", got,
                     {1'b0, 1'b0, 4'd0, 3'd0, ~A_HPOL, ~A_VPOL, 3'd0, 3'd0, 2'd0});
        end
        tick();
        tick();
        rst_a = 1'b0;

        // Edges after the first post-release edge until frame_start: (H_SYNC+H_BP) + (V_SYNC+V_BP)*H_T.
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 2 * A_FT && !found; i++) begin
            tick();
            n++;
            if (a_fs === 1'b1) found = 1'b1;
        end
        expect_int("a_frame_start_found", int'(found), 1);
        expect_int("a_restart_to_frame_start", n - 1, (A_HS + A_HB) + (A_VS + A_VB) * A_HT);

        for (int i = 0; i < 3 * A_FT; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
